// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic: DEPTH-stage valid/ready register chain carrying a
// WIDTH-bit payload, with per-stage flush and an occupancy count.
// Build option: define PIPE_STAGE_SKID_EN to give every stage a skid register.
// That makes in_ready a flop output and doubles the capacity to 2*DEPTH.
// Without the option, stage ready ripples combinationally from out_ready.
module pipe_stage_elastic #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    input  logic [DEPTH-1:0]             flush_mask,
    output logic [$clog2(2*DEPTH+1)-1:0] occ
);
    localparam int OCC_W = $clog2(2*DEPTH+1);

    logic [DEPTH-1:0][WIDTH-1:0] main_data;
    logic [DEPTH-1:0]            main_valid;
    logic [DEPTH-1:0][WIDTH-1:0] up_data;
    logic [DEPTH-1:0]            up_valid;
    logic [DEPTH-1:0]            up_ready;

    // Upstream side of each stage: stage 0 sees the input port, others the previous main
    always_comb begin
        up_valid[0] = in_valid;
        up_data[0]  = in_data;
        for (int k = 1; k < DEPTH; k++) begin
            up_valid[k] = main_valid[k-1];
            up_data[k]  = main_data[k-1];
        end
    end

`ifdef PIPE_STAGE_SKID_EN
    logic [DEPTH-1:0][WIDTH-1:0] skid_data;
    logic [DEPTH-1:0]            skid_valid;
    logic [DEPTH:0]              rdy_chain;
    logic [DEPTH-1:0]            acc;
    logic [DEPTH-1:0]            xfer;

    // Ready is the inverted skid flag, so no path exists from out_ready to in_ready
    always_comb begin
        up_ready  = ~skid_valid;
        rdy_chain = {out_ready, up_ready};
        acc       = up_valid & up_ready;
        xfer      = main_valid & rdy_chain[DEPTH:1];
    end

    // Main/skid update per stage; a flush clears both valid bits but never blocks a handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid <= '0;
            skid_valid <= '0;
            main_data  <= '0;
            skid_data  <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (!main_valid[k]) begin
                    if (acc[k]) begin
                        main_valid[k] <= 1'b1;
                        main_data[k]  <= up_data[k];
                    end
                end else if (xfer[k]) begin
                    // skid holds the older beat, so it refills main first
                    if (skid_valid[k]) begin
                        main_data[k]  <= skid_data[k];
                        skid_valid[k] <= 1'b0;
                    end else if (acc[k]) begin
                        main_data[k]  <= up_data[k];
                    end else begin
                        main_valid[k] <= 1'b0;
                    end
                end else if (acc[k]) begin
                    skid_valid[k] <= 1'b1;
                    skid_data[k]  <= up_data[k];
                end
                if (flush_mask[k]) begin
                    main_valid[k] <= 1'b0;
                    skid_valid[k] <= 1'b0;
                end
            end
        end
    end
`else
    // Ready ripples back from the output: a stage takes a beat when empty or draining
    always_comb begin
        logic r;
        r = out_ready;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            r           = !main_valid[k] || r;
            up_ready[k] = r;
        end
    end

    // Plain register per stage, advanced whenever its ready is high
    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid <= '0;
            main_data  <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (up_ready[k]) begin
                    main_valid[k] <= up_valid[k];
                    if (up_valid[k]) main_data[k] <= up_data[k];
                end
                if (flush_mask[k]) main_valid[k] <= 1'b0;
            end
        end
    end
`endif

    assign in_ready  = up_ready[0];
    assign out_valid = main_valid[DEPTH-1];
    assign out_data  = main_data[DEPTH-1];

    // Occupancy is the population count of the (post-edge) valid flops
    always_comb begin
        occ = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occ = occ + OCC_W'(main_valid[k]);
`ifdef PIPE_STAGE_SKID_EN
            occ = occ + OCC_W'(skid_valid[k]);
`endif
        end
    end
endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic (WIDTH=32, DEPTH=4); inputs are driven
// 1 time unit after the rising edge and outputs are sampled on the falling edge.
module tb_pipe_stage_elastic;
    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
`ifdef PIPE_STAGE_SKID_EN
    localparam int CAP = 2 * DEPTH;
`else
    localparam int CAP = DEPTH;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [DEPTH-1:0] flush_mask;
    logic [3:0]       occ;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q[$];

    pipe_stage_elastic #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .flush_mask(flush_mask), .occ(occ)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drain with out_ready=1 and compare every output beat against exp_q in order
    task automatic drain(input string tag, input int cycles);
        int idx = 0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (out_valid) begin
                if (idx < exp_q.size()) chk({tag, "_data"}, out_data, exp_q[idx]);
                else chk({tag, "_extra_beat"}, {31'd0, out_valid}, 32'd0);
                idx++;
            end
            tick();
        end
        chk({tag, "_count"}, idx, exp_q.size());
    endtask

    initial begin
        int acc;
        int e_occ;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush_mask = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset values
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_occ", occ, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        tick();

        // Streaming: beat i pushed in cycle i-1 shows up in cycle i+3
        out_ready = 1'b1;
        for (int c = 0; c < 24; c++) begin
            in_valid = (c < 16);
            in_data  = 32'(c + 1);
            @(negedge clk);
            e_occ = ((c < 16) ? c : 16) - ((c - 4 < 0) ? 0 : ((c - 4 > 16) ? 16 : c - 4));
            chk("stream_occ", occ, e_occ);
            if (c < 16) chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
            chk("stream_out_valid", {31'd0, out_valid}, (c >= 4 && c < 20) ? 32'd1 : 32'd0);
            if (c >= 4 && c < 20) chk("stream_out_data", out_data, 32'(c - 3));
            tick();
        end
        in_valid = 1'b0;

        // Backpressure: fill to capacity with the output stalled
        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < CAP + 6; c++) begin
            in_valid = 1'b1;
            in_data  = 32'h100 + 32'(acc);
            @(negedge clk);
            if (in_ready) acc++;
            tick();
        end
        in_valid = 1'b0;
        chk("bp_accepted", acc, CAP);
        @(negedge clk);
        chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_occ", occ, CAP);
`ifndef PIPE_STAGE_SKID_EN
        out_ready = 1'b1;
        #1;
        chk("bp_comb_ready_hi", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b0;
        #1;
        chk("bp_comb_ready_lo", {31'd0, in_ready}, 32'd0);
`endif
        tick();
        exp_q.delete();
        for (int i = 0; i < CAP; i++) exp_q.push_back(32'h100 + 32'(i));
        drain("bp_drain", CAP + 6);

        // Flush stages 0 and 2 of a full, stalled chain
        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < CAP + 6; c++) begin
            in_valid = (acc < CAP);
            in_data  = 32'hA0 + 32'(acc);
            @(negedge clk);
            if (in_valid && in_ready) acc++;
            tick();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("fl_occ_before", occ, CAP);
        tick();
        flush_mask = 4'b0101;
        tick();
        flush_mask = '0;
        @(negedge clk);
        chk("fl_occ_after", occ, CAP / 2);
        tick();
        exp_q.delete();
`ifdef PIPE_STAGE_SKID_EN
        // stages 3..0 hold (A0,A1) (A2,A3) (A4,A5) (A6,A7) as main/skid
        exp_q.push_back(32'hA0); exp_q.push_back(32'hA1);
        exp_q.push_back(32'hA4); exp_q.push_back(32'hA5);
`else
        // stages 3..0 hold A0 A1 A2 A3
        exp_q.push_back(32'hA0); exp_q.push_back(32'hA2);
`endif
        drain("fl_drain", 16);

        // Write into stage 0 while it is flushed: handshake completes, beat vanishes
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 32'hDEADBEEF; flush_mask = 4'b0001;
        @(negedge clk);
        chk("wf_in_ready", {31'd0, in_ready}, 32'd1);
        chk("wf_occ_before", occ, 32'd0);
        tick();
        in_data = 32'h55; flush_mask = '0;
        @(negedge clk);
        chk("wf_in_ready_after", {31'd0, in_ready}, 32'd1);
        chk("wf_occ_after", occ, 32'd0);
        tick();
        exp_q.delete();
        exp_q.push_back(32'h55);
        drain("wf_drain", 10);

        // Mid-stream reset discards everything
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            in_data  = 32'hC0 + 32'(c);
            tick();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("mr_occ_before", occ, 32'd3);
        tick();
        rst = 1'b1; in_valid = 1'b1; in_data = 32'h77; out_ready = 1'b1; flush_mask = 4'b1111;
        tick();
        tick();
        rst = 1'b0; in_valid = 1'b0; flush_mask = '0;
        @(negedge clk);
        chk("mr_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mr_out_data", out_data, 32'd0);
        chk("mr_occ", occ, 32'd0);
        chk("mr_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        exp_q.delete();
        drain("mr_drain", 10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
